register_file_sync: RTL and testbench

Synchronous 32-entry, 32-bit, two-read/one-write register file for the processor datapath. It holds the architectural registers and drives the operand buses into the decode/execute stage. Its internal read path is the 32-way word-select built from the team's mux library. The block adds the sequential storage, registered read outputs, write-through forwarding and a read-valid strobe.

---
 rtl/register_file_sync.sv | 105 ++++++++++
 tb/tb_register_file_sync.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/register_file_sync.sv
// register_file_sync: 32 x 32-bit architectural register file with two
// registered read ports, one write port, write-through forwarding and a
// read-valid strobe. Register 0 is hardwired to zero.
module register_file_sync #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_INDEX_WIDTH = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [REG_INDEX_WIDTH-1:0] ADDR_R1,
  input  logic [REG_INDEX_WIDTH-1:0] ADDR_R2,
  input  logic [REG_INDEX_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0]      DATA_W,
  output logic [DATA_WIDTH-1:0]      DATA_R1,
  output logic [DATA_WIDTH-1:0]      DATA_R2,
  output logic                       RD_VALID
);

  localparam int DEPTH = 2 ** REG_INDEX_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_r1_q;
  logic [DATA_WIDTH-1:0] data_r1_d;
  logic [DATA_WIDTH-1:0] data_r2_q;
  logic [DATA_WIDTH-1:0] data_r2_d;
  logic                  rd_valid_q;
  logic                  rd_valid_d;
  logic                  wr_en_s;

  // A write to index 0 is dropped so register 0 can never hold non-zero data.
  assign wr_en_s = WRITE && (ADDR_W != {REG_INDEX_WIDTH{1'b0}});

  // 32-way word select with index 0 forced to zero and same-cycle write
  // data forwarded when the read index matches the active write index.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [REG_INDEX_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0]      stored,
    input logic                       wr_en,
    input logic [REG_INDEX_WIDTH-1:0] wr_idx,
    input logic [DATA_WIDTH-1:0]      wr_data
  );
    logic [DATA_WIDTH-1:0] val;
    if (idx == {REG_INDEX_WIDTH{1'b0}}) begin
      val = {DATA_WIDTH{1'b0}};
    end else if (wr_en && (idx == wr_idx)) begin
      val = wr_data;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Next-state for storage: load the addressed register on a valid write.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_s) begin
      regs_d[ADDR_W] = DATA_W;
    end else begin
      regs_d = regs_q;
    end
  end

  // Next-state for read outputs: capture on READ, otherwise hold data and drop valid.
  always_comb begin
    data_r1_d  = data_r1_q;
    data_r2_d  = data_r2_q;
    rd_valid_d = 1'b0;
    if (READ) begin
      data_r1_d  = read_port(ADDR_R1, regs_q[ADDR_R1], wr_en_s, ADDR_W, DATA_W);
      data_r2_d  = read_port(ADDR_R2, regs_q[ADDR_R2], wr_en_s, ADDR_W, DATA_W);
      rd_valid_d = 1'b1;
    end else begin
      data_r1_d  = data_r1_q;
      data_r2_d  = data_r2_q;
      rd_valid_d = 1'b0;
    end
  end

  // State registers; reset wins over any read or write presented in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
      data_r1_q  <= {DATA_WIDTH{1'b0}};
      data_r2_q  <= {DATA_WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      data_r1_q  <= data_r1_d;
      data_r2_q  <= data_r2_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign DATA_R1  = data_r1_q;
  assign DATA_R2  = data_r2_q;
  assign RD_VALID = rd_valid_q;

endmodule

// File: tb/tb_register_file_sync.sv
// tb_register_file_sync: directed test-plan sequences plus randomized
// traffic, checked every cycle against an array-based reference model.
module tb_register_file_sync;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [4:0]  ADDR_R1 = 5'd0;
  logic [4:0]  ADDR_R2 = 5'd0;
  logic [4:0]  ADDR_W = 5'd0;
  logic [31:0] DATA_W = 32'd0;
  logic [31:0] DATA_R1;
  logic [31:0] DATA_R2;
  logic        RD_VALID;

  int checks_s   = 0;
  int failures_s = 0;

  // Reference model: architectural contents and the expected output values.
  logic [31:0] mdl_regs [32];
  logic [31:0] exp_r1;
  logic [31:0] exp_r2;
  logic        exp_valid;

  register_file_sync #(.DATA_WIDTH(32), .REG_INDEX_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST), .READ(READ), .WRITE(WRITE),
    .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .DATA_R1(DATA_R1), .DATA_R2(DATA_R2), .RD_VALID(RD_VALID)
  );

  // Free-running clock, 10 time-unit period.
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_s++;
    if (got !== exp) begin
      failures_s++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model by the architectural rules,
  // then compare all three outputs shortly after the edge.
  task automatic cycle(input logic rst, input logic rd, input logic wr,
                       input logic [4:0] ar1, input logic [4:0] ar2,
                       input logic [4:0] aw, input logic [31:0] dw);
    @(negedge CLK);
    RST = rst; READ = rd; WRITE = wr;
    ADDR_R1 = ar1; ADDR_R2 = ar2; ADDR_W = aw; DATA_W = dw;
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
      exp_r1 = 32'd0; exp_r2 = 32'd0; exp_valid = 1'b0;
    end else begin
      // A write in this cycle is already visible to this cycle's read.
      if (wr && aw != 5'd0) mdl_regs[aw] = dw;
      if (rd) begin
        exp_r1 = mdl_regs[ar1];
        exp_r2 = mdl_regs[ar2];
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
    end
    #1;
    check_val("model_r1", DATA_R1, exp_r1);
    check_val("model_r2", DATA_R2, exp_r2);
    check_val("model_valid", {31'd0, RD_VALID}, {31'd0, exp_valid});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
    exp_r1 = 32'd0; exp_r2 = 32'd0; exp_valid = 1'b0;

    // Reset, then read 5 and 31.
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    check_val("reset_r1", DATA_R1, 32'd0);
    check_val("reset_valid", {31'd0, RD_VALID}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 5'd5, 5'd31, 5'd0, 32'd0);
    check_val("rst_read_r1", DATA_R1, 32'd0);
    check_val("rst_read_r2", DATA_R2, 32'd0);
    check_val("rst_read_valid", {31'd0, RD_VALID}, 32'd1);

    // Write every register, then read pairs (i, 32-i).
    for (int i = 1; i < 32; i++)
      cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'(i), 32'hA5A50000 + 32'(i));
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 5'(i), 5'(32 - i), 5'd0, 32'd0);
      check_val("wall_r1", DATA_R1, 32'hA5A50000 + 32'(i));
      check_val("wall_r2", DATA_R2, 32'hA5A50000 + 32'(32 - i));
    end
    cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    check_val("read_r0", DATA_R1, 32'd0);

    // R0 protection.
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
    cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    check_val("r0_protect", DATA_R1, 32'd0);
    // Forwarding on a simultaneous write to index 0 must not happen either.
    cycle(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
    check_val("r0_no_fwd", DATA_R1, 32'd0);

    // Write-through forwarding.
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h11111111);
    cycle(1'b0, 1'b1, 1'b1, 5'd7, 5'd8, 5'd7, 32'h22222222);
    check_val("fwd_r1", DATA_R1, 32'h22222222);
    check_val("fwd_r2", DATA_R2, 32'hA5A50008);
    cycle(1'b0, 1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 32'd0);
    check_val("fwd_after", DATA_R1, 32'h22222222);
    check_val("same_addr", DATA_R2, 32'h22222222);

    // Hold while READ=0 and RD_VALID pulse.
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h33);
    cycle(1'b0, 1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'd0);
    check_val("hold_first", DATA_R1, 32'h33);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 5'(10 + i), 5'(20 + i), 5'd0, 32'd0);
      check_val("hold_r1", DATA_R1, 32'h33);
      check_val("hold_valid", {31'd0, RD_VALID}, 32'd0);
    end

    // Reset mid-operation discards the concurrent read and write.
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h99);
    cycle(1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 32'h1234);
    check_val("midrst_r1", DATA_R1, 32'd0);
    check_val("midrst_valid", {31'd0, RD_VALID}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 5'd9, 5'd3, 5'd0, 32'd0);
    check_val("midrst_r9", DATA_R1, 32'd0);
    check_val("midrst_r3", DATA_R2, 32'd0);

    // Randomized traffic; narrow address range raises forwarding/collision rates.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a1, a2, aw;
      a1 = (n % 2 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a2 = 5'($urandom);
      aw = (n % 3 == 0) ? a1 : 5'($urandom_range(0, 3));
      cycle(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom),
            a1, a2, aw, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end

endmodule
